// File: rtl/alu_result_demux_if.sv
`default_nettype none
// ============================================================================
// alu_result_demux_if : producer and consumer handshake bundle for the result demux
// Revision: 1.0
// ============================================================================
interface alu_result_demux_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   // The demux itself
   modport slave (
      input  in_data, in_sel, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );

   // Producer and consumers
   modport master (
      output in_data, in_sel, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );
endinterface
`default_nettype wire

// File: rtl/alu_result_demux.sv
`default_nettype none
// ============================================================================
// alu_result_demux : 1-to-2 ALU result router, one FIFO and one delivery counter per destination
// Revision: 1.0
// ============================================================================
module alu_result_demux #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   alu_result_demux_if.slave bus_if
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

   logic [1:0]       full_w;
   logic [1:0]       valid_w;
   logic [1:0]       ready_w;
   logic [WIDTH-1:0] head_w [2];
   logic [CNT_W-1:0] cnt_w  [2];

   assign ready_w = {bus_if.out1_ready, bus_if.out0_ready};

   // Readiness follows only the addressed FIFO so a stalled consumer never blocks the other
   assign bus_if.in_ready   = ~full_w[bus_if.in_sel];

   assign bus_if.out0_data  = head_w[0];
   assign bus_if.out0_valid = valid_w[0];
   assign bus_if.out1_data  = head_w[1];
   assign bus_if.out1_valid = valid_w[1];
   assign bus_if.cnt0       = cnt_w[0];
   assign bus_if.cnt1       = cnt_w[1];

   for (genvar g = 0; g < 2; g++) begin : g_dest
      localparam logic MY_SEL = 1'(g);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [OCC_W-1:0] occ_q, occ_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             push_w;
      logic             pop_w;

      assign full_w[g]  = (occ_q == DEPTH_OCC);
      assign valid_w[g] = (occ_q != '0);
      assign push_w     = bus_if.in_valid & ~full_w[g] & (bus_if.in_sel == MY_SEL);
      assign pop_w      = valid_w[g] & ready_w[g];
      assign head_w[g]  = mem_q[rd_ptr_q];
      assign cnt_w[g]   = cnt_q;

      always_comb begin
         rd_ptr_d = rd_ptr_q;
         wr_ptr_d = wr_ptr_q;
         occ_d    = occ_q;
         cnt_d    = cnt_q;
         if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
         end
         case ({push_w, pop_w})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
         end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
         end
      end

      // Storage has no reset; contents are meaningless until the pointers say otherwise
      always_ff @(posedge clk) begin
         if (!rst && push_w) begin
            mem_q[wr_ptr_q] <= bus_if.in_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_demux.sv
`default_nettype none
// ============================================================================
// tb_alu_result_demux : directed vector table plus long wrap stream for alu_result_demux
// Revision: 1.0
// ============================================================================
module tb_alu_result_demux;
   localparam int N_WRAP = 70000;
   localparam int BUDGET = 95000;

   typedef struct {
      logic        rst;
      logic        iv;
      logic        sel;
      logic [31:0] din;
      logic        r0;
      logic        r1;
      logic        chk;
      logic        erdy;
      logic        ev0;
      logic [31:0] ed0;
      logic        ev1;
      logic [31:0] ed1;
      logic [15:0] ec0;
      logic [15:0] ec1;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_result_demux_if #(.WIDTH(32), .CNT_W(16)) bus_if ();

   alu_result_demux #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic add(input logic rst_v, input logic iv, input logic sel, input logic [31:0] din,
                      input logic r0, input logic r1, input logic chk, input logic erdy,
                      input logic ev0, input logic [31:0] ed0, input logic ev1, input logic [31:0] ed1,
                      input logic [15:0] ec0, input logic [15:0] ec1);
      vec_t v;
      v.rst = rst_v; v.iv = iv; v.sel = sel; v.din = din; v.r0 = r0; v.r1 = r1; v.chk = chk;
      v.erdy = erdy; v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1; v.ec0 = ec0; v.ec1 = ec1;
      vecs.push_back(v);
   endtask

   initial begin
      bus_if.in_valid   = 1'b0;
      bus_if.in_sel     = 1'b0;
      bus_if.in_data    = '0;
      bus_if.out0_ready = 1'b1;
      bus_if.out1_ready = 1'b1;

      // Each row: inputs for one cycle, expected state observed before that cycle's edge
      //   rst iv sel din           r0 r1 chk rdy v0 d0            v1 d1            c0 c1
      add(1, 0, 0, 32'h0,          1, 1, 0,  0,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 0, 1, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 0, 1, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 1, 0, 32'hDEADBEEF,   1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 1, 1, 32'h00000001,   1, 1, 1,  1,  1, 32'hDEADBEEF, 0, 32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        1, 32'h00000001, 1, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        1, 1);
      // backpressure on port 0, isolation of port 1
      add(0, 1, 0, 32'h11,         0, 1, 1,  1,  0, 32'h0,        0, 32'h0,        1, 1);
      add(0, 1, 0, 32'h22,         0, 1, 1,  1,  1, 32'h11,       0, 32'h0,        1, 1);
      add(0, 1, 0, 32'h99,         0, 1, 1,  0,  1, 32'h11,       0, 32'h0,        1, 1);
      add(0, 1, 1, 32'h33,         0, 1, 1,  1,  1, 32'h11,       0, 32'h0,        1, 1);
      add(0, 0, 0, 32'h0,          0, 1, 1,  0,  1, 32'h11,       1, 32'h33,       1, 1);
      add(0, 0, 0, 32'h0,          1, 1, 1,  0,  1, 32'h11,       0, 32'h0,        1, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  1, 32'h22,       0, 32'h0,        2, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        3, 2);
      // full FIFO with simultaneous pop: no full-through
      add(0, 1, 0, 32'hA0,         0, 1, 1,  1,  0, 32'h0,        0, 32'h0,        3, 2);
      add(0, 1, 0, 32'hA1,         0, 1, 1,  1,  1, 32'hA0,       0, 32'h0,        3, 2);
      add(0, 1, 0, 32'hA2,         1, 1, 1,  0,  1, 32'hA0,       0, 32'h0,        3, 2);
      add(0, 1, 0, 32'hA2,         1, 1, 1,  1,  1, 32'hA1,       0, 32'h0,        4, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  1, 32'hA2,       0, 32'h0,        5, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        6, 2);
      // push into empty with ready high, then hold stalled head
      add(0, 1, 0, 32'hB0,         1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        6, 2);
      add(0, 0, 0, 32'h0,          0, 1, 1,  1,  1, 32'hB0,       0, 32'h0,        6, 2);
      add(0, 0, 0, 32'h0,          0, 1, 1,  1,  1, 32'hB0,       0, 32'h0,        6, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  1, 32'hB0,       0, 32'h0,        6, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        7, 2);
      // simultaneous pops on both ports
      add(0, 1, 0, 32'hC0,         0, 0, 1,  1,  0, 32'h0,        0, 32'h0,        7, 2);
      add(0, 1, 1, 32'hC1,         0, 0, 1,  1,  1, 32'hC0,       0, 32'h0,        7, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  1, 32'hC0,       1, 32'hC1,       7, 2);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        8, 3);
      // reset mid-operation beats a push and two pops in the same cycle
      add(0, 1, 0, 32'hE0,         0, 0, 1,  1,  0, 32'h0,        0, 32'h0,        8, 3);
      add(0, 1, 1, 32'hE1,         0, 0, 1,  1,  1, 32'hE0,       0, 32'h0,        8, 3);
      add(1, 1, 0, 32'hEE,         1, 1, 1,  1,  1, 32'hE0,       1, 32'hE1,       8, 3);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 1, 0, 32'hF0,         1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        0, 0);
      add(0, 1, 1, 32'hF1,         1, 1, 1,  1,  1, 32'hF0,       0, 32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        1, 32'hF1,       1, 0);
      add(0, 0, 0, 32'h0,          1, 1, 1,  1,  0, 32'h0,        0, 32'h0,        1, 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst               = vecs[i].rst;
         bus_if.in_valid   = vecs[i].iv;
         bus_if.in_sel     = vecs[i].sel;
         bus_if.in_data    = vecs[i].din;
         bus_if.out0_ready = vecs[i].r0;
         bus_if.out1_ready = vecs[i].r1;
         #2;
         if (vecs[i].chk) begin
            check($sformatf("row%0d_in_ready", i), 32'(bus_if.in_ready), 32'(vecs[i].erdy));
            check($sformatf("row%0d_out0_valid", i), 32'(bus_if.out0_valid), 32'(vecs[i].ev0));
            check($sformatf("row%0d_out1_valid", i), 32'(bus_if.out1_valid), 32'(vecs[i].ev1));
            check($sformatf("row%0d_cnt0", i), 32'(bus_if.cnt0), 32'(vecs[i].ec0));
            check($sformatf("row%0d_cnt1", i), 32'(bus_if.cnt1), 32'(vecs[i].ec1));
            if (vecs[i].ev0) check($sformatf("row%0d_out0_data", i), bus_if.out0_data, vecs[i].ed0);
            if (vecs[i].ev1) check($sformatf("row%0d_out1_data", i), bus_if.out1_data, vecs[i].ed1);
         end
      end

      // Long stream to port 1: pointer wrap and counter wrap
      begin
         logic [31:0] q[$];
         logic [31:0] word;
         int sent = 0;
         int recv = 0;
         int cyc  = 0;
         int o0_seen = 0;

         @(negedge clk);
         rst             = 1'b1;
         bus_if.in_valid = 1'b0;
         @(negedge clk);
         rst  = 1'b0;
         word = $urandom;
         while (recv < N_WRAP && cyc < BUDGET) begin
            @(negedge clk);
            bus_if.in_valid   = (sent < N_WRAP);
            bus_if.in_sel     = 1'b1;
            bus_if.in_data    = word;
            bus_if.out0_ready = 1'b1;
            bus_if.out1_ready = ($urandom_range(0, 15) != 0);
            #2;
            if (bus_if.out0_valid) o0_seen++;
            if (bus_if.out1_valid && bus_if.out1_ready) begin
               if (q.size() == 0) begin
                  check("wrap_unexpected_pop", bus_if.out1_data, 32'hFFFF_FFFF ^ bus_if.out1_data);
               end else begin
                  check("wrap_data", bus_if.out1_data, q[0]);
                  void'(q.pop_front());
               end
               recv++;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
               q.push_back(word);
               sent++;
               word = $urandom;
            end
            cyc++;
         end
         check("wrap_received", 32'(recv), 32'(N_WRAP));
         @(negedge clk);
         bus_if.in_valid = 1'b0;
         #2;
         check("wrap_out0_idle", 32'(o0_seen), 32'd0);
         check("wrap_out1_drained", 32'(bus_if.out1_valid), 32'd0);
         check("wrap_cnt1", 32'(bus_if.cnt1), 32'(N_WRAP % 65536));
         check("wrap_cnt0", 32'(bus_if.cnt0), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_result_demux.md
Name: alu_result_demux

Overview:
- 1-to-2 demultiplexer for the 32-bit ALU datapath; the dispatch-side counterpart of the 2-to-1 operand select.
- Accepts one ALU result per handshake and routes it by in_sel to one of two consumers, e.g. register write-back (port 0) and flag/compare unit (port 1).
- Each destination has its own small FIFO, so a stalled consumer only blocks traffic addressed to it.
- Also keeps per-destination transfer counters for debug.

Parameters:
- WIDTH, 32, data width of results.
- DEPTH, 2, entries per destination FIFO; power of two, at least 2.
- CNT_W, 16, width of each delivered-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  result to route.
- in_sel  input  1  destination: 0 selects out0, 1 selects out1.
- in_valid  input  1  producer has a result.
- in_ready  output  1  selected destination FIFO can accept.
- out0_data  output  WIDTH  head of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 accepts.
- out1_data  output  WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 accepts.
- cnt0  output  CNT_W  count of completed out0 transfers.
- cnt1  output  CNT_W  count of completed out1 transfers.

Behaviour:
- Reset: one clock with rst=1 is required. On that edge both FIFOs are emptied (pointers and occupancy set to 0), out0_valid=out1_valid=0, cnt0=cnt1=0.
- Reset takes priority over any push or pop in the same cycle.
- Data outputs after reset are don't-care while valid=0.
- Reset mid-operation discards all buffered entries.
- in_ready is combinational: it equals NOT full of FIFO[in_sel]. It does not depend on in_valid, and it is 1 during the rst cycle only if that FIFO is not full.
- Push: occurs when in_valid && in_ready at a rising edge. in_data is written to FIFO[in_sel].
- Push to pop latency: a pushed word is visible on outN_data with outN_valid=1 on the cycle after the push edge. There is no combinational bypass from input to output.
- Pop: occurs when outN_valid && outN_ready. The head advances at that edge.
- Pops on out0 and out1 are independent and may occur in the same cycle.
- outN_data is the registered-array head, read through the read pointer. It must remain stable while outN_valid=1 and outN_ready=0.
- Push and pop on the same FIFO in the same cycle:
  - When the FIFO is not full, both take effect and occupancy is unchanged.
  - When the FIFO is full, in_ready=0 and no push occurs, even if a pop happens that cycle. There is no full-through.
  - When the FIFO is empty, the push takes effect and no pop occurs (valid was 0).
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Occupancy is a counter from 0 to DEPTH.
- Ordering: FIFO order is preserved per destination. There is no ordering guarantee across destinations.
- in_sel and in_data are sampled only on a push edge. in_sel may change freely while in_valid=0 or in_ready=0. The producer must hold in_data/in_sel stable while in_valid=1 and not yet accepted.
- Counters: cntN increments by 1 on each outN pop and wraps from 2^CNT_W-1 to 0 with no saturation.

Test Plan:
- Reset and idle: assert rst 1 cycle, then idle 5 cycles -> out0_valid=out1_valid=0, cnt0=cnt1=0, in_ready=1 for in_sel=0 and for in_sel=1.
- Basic routing with both readys held at 1:
  - Push 0xDEADBEEF with sel=0 -> next cycle out0_valid=1, out0_data=0xDEADBEEF, out1_valid=0.
  - Then push 0x00000001 with sel=1 -> out1_data=0x00000001; cnt0=1, cnt1=1 afterwards.
- Backpressure and isolation, with out0_ready=0 and DEPTH=2:
  - Push 0x11 and 0x22 to sel=0 -> in_ready=0 while in_sel=0.
  - Then with in_sel=1, in_ready=1 and 0x33 reaches out1.
  - Release out0_ready -> out0 delivers 0x11 then 0x22 in order.
- Full with simultaneous pop: fill FIFO 0, then hold in_valid=1, sel=0, out0_ready=1 -> no push in the first cycle (in_ready=0). The push is accepted on the following cycle, and no word is lost or duplicated.
- Wrap and counter: stream 70000 words to out1 with random out1_ready -> data matches the sent sequence (pointer wrap exercised) and cnt1 = 70000 mod 65536 = 4464.
- Reset mid-operation: with both FIFOs holding 1 entry, assert rst for 1 cycle -> out0_valid=out1_valid=0, cnt0=cnt1=0, and the old data never reappears on later pops.
